// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one external binary-to-BCD converter between two requesters,
// with per-requester result storage and a 4-digit scan display. Define BCD_LEADING_ZERO_BLANK_EN to blank leading zeros.
module bcd_conv_arbiter #(
   parameter int SETTLE_CYCLES = 1,
   parameter int REFRESH_DIV   = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_valid,
   input  logic [9:0]  a_data,
   output logic        a_ready,
   output logic        a_done,
   input  logic        b_valid,
   input  logic [9:0]  b_data,
   output logic        b_ready,
   output logic        b_done,
   output logic [9:0]  conv_bin,
   input  logic [11:0] conv_bcd,
   input  logic        disp_sel,
   output logic        a_ovf,
   output logic        b_ovf,
   output logic [3:0]  an,
   output logic [3:0]  digit_bcd
);

   localparam int   SCAN_W  = $clog2(REFRESH_DIV);
   localparam logic GRANT_A = 1'b0;
   localparam logic GRANT_B = 1'b1;

   typedef enum logic {IDLE, CONV} state_t;

   state_t      state, state_nxt;
   logic        last_grant;
   logic [3:0]  settle_cnt;
   logic        grant_a, grant_b, a_fire, b_fire, capture;
   logic [11:0] stored_a, stored_b;

   logic [SCAN_W-1:0] scan_cnt;
   logic [1:0]        digit_idx, idx_nxt;
   logic              scan_wrap;
   logic [11:0]       sel_val;
   logic [3:0]        an_nxt, digit_nxt;

   function automatic logic [9:0] clamp(input logic [9:0] d);
      return (d > 10'd999) ? 10'd999 : d;
   endfunction

   // On a tie the requester that was not served last wins.
   assign grant_a = a_valid && (!b_valid || last_grant == GRANT_B);
   assign grant_b = b_valid && (!a_valid || last_grant == GRANT_A);
   assign a_fire  = a_valid && a_ready;
   assign b_fire  = b_valid && b_ready;
   assign capture = (state == CONV) && (settle_cnt == 4'(SETTLE_CYCLES - 1));

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (a_fire || b_fire) state_nxt = CONV;
         CONV:    if (capture)          state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      a_ready = 1'b0;
      b_ready = 1'b0;
      if (!rst && state == IDLE) begin
         a_ready = grant_a;
         b_ready = grant_b;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= GRANT_B;
         settle_cnt <= '0;
         conv_bin   <= '0;
         stored_a   <= '0;
         stored_b   <= '0;
         a_ovf      <= 1'b0;
         b_ovf      <= 1'b0;
         a_done     <= 1'b0;
         b_done     <= 1'b0;
      end else begin
         a_done <= 1'b0;
         b_done <= 1'b0;
         if (a_fire) begin
            conv_bin   <= clamp(a_data);
            a_ovf      <= (a_data > 10'd999);
            last_grant <= GRANT_A;
            settle_cnt <= '0;
         end else if (b_fire) begin
            conv_bin   <= clamp(b_data);
            b_ovf      <= (b_data > 10'd999);
            last_grant <= GRANT_B;
            settle_cnt <= '0;
         end else if (state == CONV) begin
            settle_cnt <= settle_cnt + 4'd1;
            if (capture) begin
               if (last_grant == GRANT_A) begin
                  stored_a <= conv_bcd;
                  a_done   <= 1'b1;
               end else begin
                  stored_b <= conv_bcd;
                  b_done   <= 1'b1;
               end
            end
         end
      end
   end

   // Display outputs are decoded for the digit that becomes active at the next wrap.
   assign scan_wrap = (scan_cnt == SCAN_W'(REFRESH_DIV - 1));
   assign idx_nxt   = digit_idx + 2'd1;
   assign sel_val   = disp_sel ? stored_b : stored_a;

   always_comb begin
      an_nxt    = 4'b1111;
      digit_nxt = 4'd0;
      case (idx_nxt)
         2'd0: begin
            an_nxt    = 4'b1110;
            digit_nxt = sel_val[3:0];
         end
         2'd1: begin
`ifdef BCD_LEADING_ZERO_BLANK_EN
            if (sel_val[11:4] != 8'd0) begin
               an_nxt    = 4'b1101;
               digit_nxt = sel_val[7:4];
            end
`else
            an_nxt    = 4'b1101;
            digit_nxt = sel_val[7:4];
`endif
         end
         2'd2: begin
`ifdef BCD_LEADING_ZERO_BLANK_EN
            if (sel_val[11:8] != 4'd0) begin
               an_nxt    = 4'b1011;
               digit_nxt = sel_val[11:8];
            end
`else
            an_nxt    = 4'b1011;
            digit_nxt = sel_val[11:8];
`endif
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt  <= '0;
         digit_idx <= 2'd0;
         an        <= 4'b1111;
         digit_bcd <= 4'd0;
      end else if (scan_wrap) begin
         scan_cnt  <= '0;
         digit_idx <= idx_nxt;
         an        <= an_nxt;
         digit_bcd <= digit_nxt;
      end else begin
         scan_cnt  <= scan_cnt + SCAN_W'(1);
      end
   end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed self-checking bench for bcd_conv_arbiter; models the external converter
// and observes stored values through the scan display.
module tb_bcd_conv_arbiter;

   localparam int R = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_valid, b_valid;
   logic [9:0]  a_data, b_data;
   logic        a_ready, b_ready, a_done, b_done;
   logic [9:0]  conv_bin;
   logic [11:0] conv_bcd;
   logic        disp_sel;
   logic        a_ovf, b_ovf;
   logic [3:0]  an, digit_bcd;

   int checks   = 0;
   int failures = 0;

   bcd_conv_arbiter #(.SETTLE_CYCLES(1), .REFRESH_DIV(R)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready), .a_done(a_done),
      .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready), .b_done(b_done),
      .conv_bin(conv_bin), .conv_bcd(conv_bcd), .disp_sel(disp_sel),
      .a_ovf(a_ovf), .b_ovf(b_ovf), .an(an), .digit_bcd(digit_bcd)
   );

   always #5 clk = ~clk;

   // External combinational converter.
   int conv_int;
   always_comb begin
      conv_int = int'(conv_bin);
      conv_bcd = {4'(conv_int / 100), 4'((conv_int / 10) % 10), 4'(conv_int % 10)};
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
      step; step;
      rst = 1'b0;
   endtask

   task automatic handshake(input bit is_b, input logic [9:0] d);
      int n = 0;
      if (is_b) begin b_valid = 1'b1; b_data = d; end
      else      begin a_valid = 1'b1; a_data = d; end
      #1;
      while (!(is_b ? b_ready : a_ready) && n < 10) begin step; n++; end
      checks++;
      if (!(is_b ? b_ready : a_ready)) begin
         failures++;
         $display("FAIL ready_timeout: got ready=0 expected 1 (is_b=%0d)", is_b);
      end
      step;
      a_valid = 1'b0; b_valid = 1'b0;
   endtask

   task automatic wait_done(input bit is_b);
      int n = 0;
      while (!(is_b ? b_done : a_done) && n < 10) begin step; n++; end
      checks++;
      if (!(is_b ? b_done : a_done)) begin
         failures++;
         $display("FAIL done_timeout: got done=0 expected 1 (is_b=%0d)", is_b);
      end
      step;
   endtask

   task automatic read_display(input logic sel, output logic [11:0] v);
      disp_sel = sel;
      v = 12'h000;
      repeat (8 * R) step;
      repeat (4 * R) begin
         step;
         case (an)
            4'b1110: v[3:0]  = digit_bcd;
            4'b1101: v[7:4]  = digit_bcd;
            4'b1011: v[11:8] = digit_bcd;
            default: ;
         endcase
      end
   endtask

   task automatic sync_ones;
      int n = 0;
      while (an == 4'b1110 && n < 8 * R) begin step; n++; end
      while (an != 4'b1110 && n < 8 * R) begin step; n++; end
      checks++;
      if (an !== 4'b1110) begin
         failures++;
         $display("FAIL scan_sync: got an=%b expected 1110", an);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; a_data = 10'd1; b_data = 10'd2; disp_sel = 1'b0;
      step; step;
      checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin failures++;
         $display("FAIL reset_ready: got a=%b b=%b expected 0 0", a_ready, b_ready); end
      checks++; if (an !== 4'b1111 || digit_bcd !== 4'd0) begin failures++;
         $display("FAIL reset_disp: got an=%b d=%h expected 1111 0", an, digit_bcd); end
      checks++; if (conv_bin !== 10'd0) begin failures++;
         $display("FAIL reset_conv_bin: got %0d expected 0", conv_bin); end
      checks++; if ({a_ovf, b_ovf, a_done, b_done} !== 4'b0000) begin failures++;
         $display("FAIL reset_flags: got %b expected 0000", {a_ovf, b_ovf, a_done, b_done}); end
      a_valid = 1'b0; b_valid = 1'b0; rst = 1'b0;
      step;
   endtask

   task automatic test_single;
      logic [11:0] v;
      a_valid = 1'b1; a_data = 10'd255;
      #1;
      checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin failures++;
         $display("FAIL single_ready: got a=%b b=%b expected 1 0", a_ready, b_ready); end
      step;
      a_valid = 1'b0;
      checks++; if (conv_bin !== 10'd255) begin failures++;
         $display("FAIL single_conv_bin: got %0d expected 255", conv_bin); end
      checks++; if (a_done !== 1'b0 || a_ready !== 1'b0) begin failures++;
         $display("FAIL single_conv_state: got done=%b ready=%b expected 0 0", a_done, a_ready); end
      step;
      checks++; if (a_done !== 1'b1 || a_ovf !== 1'b0) begin failures++;
         $display("FAIL single_done: got done=%b ovf=%b expected 1 0", a_done, a_ovf); end
      step;
      checks++; if (a_done !== 1'b0) begin failures++;
         $display("FAIL single_done_pulse: got %b expected 0", a_done); end
      read_display(1'b0, v);
      checks++; if (v !== 12'h255) begin failures++;
         $display("FAIL single_stored_a: got %h expected 255", v); end
   endtask

   task automatic test_back_to_back;
      int g[8];
      int ng = 0;
      int both = 0;
      logic [11:0] v;
      do_reset;
      a_valid = 1'b1; b_valid = 1'b1; a_data = 10'd123; b_data = 10'd456;
      #1;
      for (int i = 0; i < 8; i++) begin
         if (a_ready && b_ready) both++;
         if (a_ready) begin g[ng] = 0; ng++; end
         else if (b_ready) begin g[ng] = 1; ng++; end
         step;
      end
      a_valid = 1'b0; b_valid = 1'b0;
      checks++; if (both != 0) begin failures++;
         $display("FAIL b2b_both_ready: got %0d cycles expected 0", both); end
      checks++; if (ng != 4) begin failures++;
         $display("FAIL b2b_grant_count: got %0d expected 4", ng); end
      else begin
         checks++; if (g[0] != 0 || g[1] != 1 || g[2] != 0 || g[3] != 1) begin failures++;
            $display("FAIL b2b_order: got %0d%0d%0d%0d expected 0101", g[0], g[1], g[2], g[3]); end
      end
      read_display(1'b0, v);
      checks++; if (v !== 12'h123) begin failures++;
         $display("FAIL b2b_stored_a: got %h expected 123", v); end
      read_display(1'b1, v);
      checks++; if (v !== 12'h456) begin failures++;
         $display("FAIL b2b_stored_b: got %h expected 456", v); end
   endtask

   task automatic test_saturate;
      logic [11:0] v;
      handshake(1'b1, 10'd1023);
      checks++; if (conv_bin !== 10'd999 || b_ovf !== 1'b1) begin failures++;
         $display("FAIL sat_clamp: got bin=%0d ovf=%b expected 999 1", conv_bin, b_ovf); end
      wait_done(1'b1);
      read_display(1'b1, v);
      checks++; if (v !== 12'h999) begin failures++;
         $display("FAIL sat_stored_b: got %h expected 999", v); end
      handshake(1'b1, 10'd5);
      checks++; if (conv_bin !== 10'd5 || b_ovf !== 1'b0) begin failures++;
         $display("FAIL sat_clear: got bin=%0d ovf=%b expected 5 0", conv_bin, b_ovf); end
      wait_done(1'b1);
      read_display(1'b1, v);
      checks++; if (v !== 12'h005) begin failures++;
         $display("FAIL sat_stored_b5: got %h expected 005", v); end
   endtask

   task automatic test_reset_mid_conv;
      logic [11:0] v;
      handshake(1'b0, 10'd300);
      rst = 1'b1;
      step;
      rst = 1'b0;
      checks++; if (a_done !== 1'b0 || an !== 4'b1111 || conv_bin !== 10'd0) begin failures++;
         $display("FAIL midrst_state: got done=%b an=%b bin=%0d expected 0 1111 0", a_done, an, conv_bin); end
      step;
      checks++; if (a_done !== 1'b0) begin failures++;
         $display("FAIL midrst_no_done: got %b expected 0", a_done); end
      a_valid = 1'b1; a_data = 10'd1;
      #1;
      checks++; if (a_ready !== 1'b1) begin failures++;
         $display("FAIL midrst_idle: got a_ready=%b expected 1", a_ready); end
      a_valid = 1'b0;
      read_display(1'b0, v);
      checks++; if (v !== 12'h000) begin failures++;
         $display("FAIL midrst_stored_a: got %h expected 000", v); end
   endtask

   task automatic test_scan;
      logic [3:0] exp_an[4];
      logic [3:0] exp_d[4];
      exp_an[0] = 4'b1110; exp_an[1] = 4'b1101; exp_an[2] = 4'b1011; exp_an[3] = 4'b1111;
      exp_d[0]  = 4'd7;    exp_d[1]  = 4'd0;    exp_d[2]  = 4'd4;    exp_d[3]  = 4'd0;
      handshake(1'b1, 10'd407);
      wait_done(1'b1);
      disp_sel = 1'b1;
      repeat (8 * R) step;
      sync_ones;
      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < R; c++) begin
            checks++;
            if (an !== exp_an[s] || digit_bcd !== exp_d[s]) begin failures++;
               $display("FAIL scan_407 slot%0d cyc%0d: got an=%b d=%h expected %b %h",
                        s, c, an, digit_bcd, exp_an[s], exp_d[s]); end
            step;
         end
      end
   endtask

   task automatic test_blank;
      logic [3:0] exp_an[4];
      logic [3:0] exp_d[4];
      exp_d[0] = 4'd7; exp_d[1] = 4'd0; exp_d[2] = 4'd0; exp_d[3] = 4'd0;
      exp_an[0] = 4'b1110; exp_an[3] = 4'b1111;
`ifdef BCD_LEADING_ZERO_BLANK_EN
      exp_an[1] = 4'b1111; exp_an[2] = 4'b1111;
`else
      exp_an[1] = 4'b1101; exp_an[2] = 4'b1011;
`endif
      handshake(1'b0, 10'd7);
      wait_done(1'b0);
      disp_sel = 1'b0;
      repeat (8 * R) step;
      sync_ones;
      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < R; c++) begin
            checks++;
            if (an !== exp_an[s] || digit_bcd !== exp_d[s]) begin failures++;
               $display("FAIL blank_007 slot%0d cyc%0d: got an=%b d=%h expected %b %h",
                        s, c, an, digit_bcd, exp_an[s], exp_d[s]); end
            step;
         end
      end
   endtask

   initial begin
      rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
      a_data = '0; b_data = '0; disp_sel = 1'b0;
      test_reset;
      test_single;
      test_back_to_back;
      test_saturate;
      test_reset_mid_conv;
      test_scan;
      test_blank;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
